// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-requester data-memory arbiter: FSM states,
// the registered command layout and the access-legality check.
package dmem_arb_pkg;

  localparam int MEM_BYTES_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        valid;
    logic        owner;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Misaligned or past the last full word of the memory.
  function automatic logic addr_err(input logic [31:0] addr, input int mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > 32'(mem_bytes - 4));
  endfunction

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Two-way priority selector: a lone request wins, a tie goes to the
// requester named by ptr. Output is one-hot or zero.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with a one-cycle command register,
// bus locking and access-error reporting. Define DMEM_ARB_FIXED_PRIO_EN
// for fixed priority (requester 0 wins ties); round-robin otherwise.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int NREQ      = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] we_i,
  input  logic [NREQ-1:0] lock_i,
  input  logic [31:0]     addr_i  [NREQ],
  input  logic [31:0]     wdata_i [NREQ],
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] rvalid_o,
  output logic [NREQ-1:0] err_o,
  output logic [31:0]     rdata_o,
  output logic [31:0]     mem_addr_o,
  output logic [31:0]     mem_wdata_o,
  output logic            mem_write_o,
  output logic            mem_read_o,
  input  logic [31:0]     mem_rdata_i
);

  arb_state_e state;
  logic       lock_owner;
  logic       ptr;
  logic [1:0] req_eff;
  logic [1:0] pick;
  logic       gidx;
  cmd_t       cmd_p0;
  cmd_t       cmd_p1;

  // While locked, the other requester is invisible to the selector.
  always_comb begin
    req_eff = req_i;
    if (state == LOCKED) req_eff = lock_owner ? (req_i & 2'b10) : (req_i & 2'b01);
  end

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign ptr = 1'b0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= 1'b0;
    else if (|pick) ptr <= ~gidx;
  end
`endif

  dmem_rr_pick u_pick (
    .req (req_eff),
    .ptr (ptr),
    .gnt (pick)
  );

  assign gnt_o = rst_n ? pick : 2'b00;
  assign gidx  = pick[1];

  // p0: grant cycle, command assembled from the winning requester
  always_comb begin
    cmd_p0       = '0;
    cmd_p0.valid = |pick;
    cmd_p0.owner = gidx;
    cmd_p0.we    = we_i[gidx];
    cmd_p0.err   = addr_err(addr_i[gidx], MEM_BYTES);
    cmd_p0.addr  = addr_i[gidx];
    cmd_p0.wdata = wdata_i[gidx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lock_owner <= 1'b0;
      cmd_p1     <= '0;
    end else begin
      if (|pick) cmd_p1 <= cmd_p0;
      else       cmd_p1.valid <= 1'b0;
      case (state)
        IDLE, ACCESS: begin
          if (!(|pick)) begin
            state <= IDLE;
          end else if (lock_i[gidx]) begin
            state      <= LOCKED;
            lock_owner <= gidx;
          end else begin
            state <= ACCESS;
          end
        end
        LOCKED: if ((|pick) && !lock_i[gidx]) state <= ACCESS;
        default: state <= IDLE;
      endcase
    end
  end

  // p1: registered command drives the memory and the response
  assign mem_addr_o  = cmd_p1.addr;
  assign mem_wdata_o = cmd_p1.wdata;
  assign mem_write_o = cmd_p1.valid & cmd_p1.we & ~cmd_p1.err;
  assign mem_read_o  = cmd_p1.valid & ~cmd_p1.we & ~cmd_p1.err;
  assign rvalid_o    = cmd_p1.valid ? (cmd_p1.owner ? 2'b10 : 2'b01) : 2'b00;
  assign err_o       = cmd_p1.err ? rvalid_o : 2'b00;
  assign rdata_o     = mem_read_o ? mem_rdata_i : 32'h0;

endmodule
